// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, redirect handling,
// and a small in-order queue that hands {pc, instr} entries to decode.
//
// state        | meaning
// IDLE         | nothing outstanding, may issue a request
// WAIT         | one request outstanding, response will be queued
// WAIT_DISCARD | one request outstanding, response will be dropped
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] fetch_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     addr_q;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic            grant, push, pop;

    // Gated by rst_n so no request is visible while reset is asserted.
    assign imem_req  = rst_n && (state_q == IDLE) && (count < CW'(DEPTH)) && !redirect_valid;
    assign imem_addr = fetch_pc_q;
    assign fetch_pc  = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    assign push      = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    assign pop       = (count != '0) && if_ready && !redirect_valid;

    assign if_valid  = (count != '0);
    assign if_pc     = q_pc[rd_ptr];
    assign if_instr  = q_instr[rd_ptr];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid)         state_d = IDLE;
                else if (redirect_valid) state_d = WAIT_DISCARD;
            end
            WAIT_DISCARD: begin
                if (imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
            end else begin
                if (grant) begin
                    addr_q     <= fetch_pc_q;
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= addr_q;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default instance plus a wrap-around RESET_PC instance.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_ready;

    logic        imem_req, if_valid;
    logic [31:0] imem_addr, fetch_pc, if_pc, if_instr;
    logic        imem_req_b, if_valid_b;
    logic [31:0] imem_addr_b, fetch_pc_b, if_pc_b, if_instr_b;

    int errors = 0;
    int checks = 0;
    bit auto_mem = 1'b0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .fetch_pc(fetch_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .fetch_pc(fetch_pc_b),
        .if_valid(if_valid_b), .if_pc(if_pc_b), .if_instr(if_instr_b), .if_ready(if_ready)
    );

    // Advance one clock; in auto mode memory answers one cycle after each grant.
    task automatic step();
        logic granted;
        granted = imem_req && imem_gnt;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rvalid = granted;
            imem_rdata  = 32'h0000_0013;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0; auto_mem = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", fetch_pc); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        checks++; if (fetch_pc_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_b got=%h exp=fffffffc", fetch_pc_b); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req got=%b/%h exp=1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_fetch, exp_entry;
        int seen;
        do_reset();
        imem_gnt = 1'b1; if_ready = 1'b1; auto_mem = 1'b1;
        exp_fetch = 32'h0; exp_entry = 32'h0; seen = 0;
        for (int c = 0; c < 30 && seen < 3; c++) begin
            if (if_valid) begin
                checks++;
                if (if_pc !== exp_entry || if_instr !== 32'h13) begin
                    errors++; $display("FAIL stream_entry got=%h/%h exp=%h/00000013", if_pc, if_instr, exp_entry);
                end
                exp_entry += 32'd4; seen++;
            end
            if (imem_req && imem_gnt) begin
                checks++;
                if (imem_addr !== exp_fetch) begin
                    errors++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, exp_fetch);
                end
                exp_fetch += 32'd4;
            end
            step();
            checks++;
            if (fetch_pc !== exp_fetch) begin errors++; $display("FAIL stream_fetch_pc got=%h exp=%h", fetch_pc, exp_fetch); end
        end
        checks++; if (seen !== 3) begin errors++; $display("FAIL stream_timeout got=%0d exp=3", seen); end
        auto_mem = 1'b0; imem_rvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_gnt = 1'b1; if_ready = 1'b0; auto_mem = 1'b1;
        repeat (10) step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_head got=%b/%h exp=1/00000000", if_valid, if_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req got=%b exp=0", imem_req); end
        checks++; if (fetch_pc !== 32'h8) begin errors++; $display("FAIL bp_fetch_pc got=%h exp=00000008", fetch_pc); end
        if_ready = 1'b1;
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin errors++; $display("FAIL bp_second got=%b/%h exp=1/00000004", if_valid, if_pc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume got=%b/%h exp=1/00000008", imem_req, imem_addr); end
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", if_valid); end
        auto_mem = 1'b0; imem_rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA0A0_A0A0; step();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; if_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hB4B4_B4B4;
        #1;
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'hA0A0_A0A0) begin errors++; $display("FAIL b2b_head got=%h/%h exp=00000000/a0a0a0a0", if_pc, if_instr); end
        step();
        imem_rvalid = 1'b0; if_ready = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'hB4B4_B4B4) begin
            errors++; $display("FAIL b2b_entry got=%b/%h/%h exp=1/00000004/b4b4b4b4", if_valid, if_pc, if_instr);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL b2b_req got=%b/%h exp=1/00000008", imem_req, imem_addr); end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_AAAA; step();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_blocked got=%b exp=0", imem_req); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got=%b exp=0", if_valid); end
        checks++; if (fetch_pc !== 32'h100) begin errors++; $display("FAIL redir_pc got=%h exp=00000100", fetch_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_discard_req got=%b exp=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_BBBB; step();
        imem_rvalid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_drop got=%b exp=0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_next got=%b/%h exp=1/00000100", imem_req, imem_addr); end

        imem_gnt = 1'b1; step();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        imem_rvalid = 1'b1; imem_rdata = 32'hCCCC_CCCC; step();
        redirect_valid = 1'b0; imem_rvalid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL coinc_nopush got=%b exp=0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL coinc_next got=%b/%h exp=1/00000200", imem_req, imem_addr); end

        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
                errors++; $display("FAIL stall_stable got=%b/%h exp=1/00000200", imem_req, imem_addr);
            end
        end
        imem_gnt = 1'b1; step();
        imem_gnt = 1'b0;
        checks++; if (fetch_pc !== 32'h204) begin errors++; $display("FAIL stall_grant got=%h exp=00000204", fetch_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++; if (imem_req_b !== 1'b1 || imem_addr_b !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", imem_req_b, imem_addr_b);
        end
        imem_gnt = 1'b1; if_ready = 1'b0; auto_mem = 1'b1;
        step();
        checks++; if (fetch_pc_b !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=00000000", fetch_pc_b); end
        step();
        checks++; if (imem_req_b !== 1'b1 || imem_addr_b !== 32'h0) begin errors++; $display("FAIL wrap_second got=%b/%h exp=1/00000000", imem_req_b, imem_addr_b); end
        checks++; if (if_valid_b !== 1'b1 || if_pc_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_entry got=%b/%h exp=1/fffffffc", if_valid_b, if_pc_b); end
        auto_mem = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_gnt = 1'b1; step();
        imem_gnt = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || fetch_pc !== 32'h0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got=%b/%h/%b exp=0/00000000/0", imem_req, fetch_pc, if_valid);
        end
        step();
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        step();
        imem_rvalid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got=%b exp=0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_idle got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_redirect();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
